tl_ul_sram_responder: RTL and testbench

- TileLink-UL manager (responder) backed by a flop-based word memory; the slave end of the A/D channel pair that the TL monitors check.
- Accepts Get/PutFullData/PutPartialData on channel A; returns AccessAckData/AccessAck on channel D with one-cycle latency and a single-entry response buffer.
- Sits behind a crossbar port as a scratchpad or test target for core and DMA initiators.

---
 rtl/tl_ul_sram_responder_if.sv | 43 ++++
 rtl/tl_ul_sram_responder.sv | 203 ++++++++++++++++++++
 tb/tb_tl_ul_sram_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_ul_sram_responder_if.sv
// TileLink-UL A/D channel bundle between an initiator (master) and a responder (slave).
// Latency: none, wires only.
// Backpressure: a_ready/d_ready valid-ready handshakes carried through unchanged.
interface tl_ul_sram_responder_if #(
  parameter int SRC_W = 4
);
  // A channel: request
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [1:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic [3:0]       a_mask;
  logic [31:0]      a_data;

  // D channel: response
  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [1:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_sink;
  logic             d_denied;
  logic             d_corrupt;
  logic [31:0]      d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backed by a flop word memory (Get/PutFull/PutPartial, illegal requests denied).
// Latency: one cycle from A fire to D valid; writes land on the A fire edge.
// Backpressure: single-entry response register, a_ready = !d_valid || d_ready; when
// TL_RESP_BACKPRESSURE_EN is defined an LFSR additionally stalls a_ready pseudo-randomly.
module tl_ul_sram_responder #(
  parameter int          SRC_W     = 4,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  tl_ul_sram_responder_if.slave  tl
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ARITH       = 3'd2;
  localparam logic [2:0] OP_LOGIC       = 3'd3;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  logic [31:0] mem [DEPTH];

  // Response register
  logic             d_valid_q;
  logic [2:0]       d_opcode_q;
  logic [1:0]       d_size_q;
  logic [SRC_W-1:0] d_source_q;
  logic             d_denied_q;
  logic             d_corrupt_q;
  logic [31:0]      d_data_q;

  // Request decode
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          size_ok;
  logic          aligned;
  logic [3:0]    lanes;
  logic          mask_ok;
  logic          legal;
  logic          a_ready_int;
  logic          a_fire;

  logic [2:0]    rsp_opcode;
  logic          rsp_denied;
  logic          rsp_corrupt;
  logic [31:0]   rsp_data;
  logic          wr_en;

  // a_param carries no meaning for this responder
  logic unused_a_param;
  assign unused_a_param = ^tl.a_param;

  assign offset   = tl.a_address - BASE_ADDR;
  assign word_idx = offset[AW+1:2];
  assign in_range = offset < SPAN;
  assign size_ok  = tl.a_size != 2'd3;

`ifdef TL_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running; stalls A when its low bits are zero
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign a_ready_int = (!d_valid_q || tl.d_ready) && (lfsr[1:0] != 2'b00);
`else
  assign a_ready_int = !d_valid_q || tl.d_ready;
`endif

  assign a_fire = tl.a_valid && a_ready_int;

  // Byte lanes implied by size and the low address bits, plus natural alignment
  always_comb begin
    lanes   = 4'b0000;
    aligned = 1'b0;
    case (tl.a_size)
      2'd0: begin
        lanes   = 4'b0001 << tl.a_address[1:0];
        aligned = 1'b1;
      end
      2'd1: begin
        lanes   = tl.a_address[1] ? 4'b1100 : 4'b0011;
        aligned = ~tl.a_address[0];
      end
      2'd2: begin
        lanes   = 4'b1111;
        aligned = (tl.a_address[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  // Get/PutFull need the exact lane set; PutPartial needs a nonempty subset of it
  always_comb begin
    mask_ok = (tl.a_mask == lanes);
    if (tl.a_opcode == OP_PUT_PARTIAL) begin
      mask_ok = (tl.a_mask != 4'b0000) && ((tl.a_mask & ~lanes) == 4'b0000);
    end
  end

  assign legal = in_range && size_ok && aligned && mask_ok;

  // Build the D beat for the current A request and decide whether it writes
  always_comb begin
    rsp_opcode  = D_ACCESS_ACK;
    rsp_denied  = 1'b0;
    rsp_corrupt = 1'b0;
    rsp_data    = 32'h0;
    wr_en       = 1'b0;
    case (tl.a_opcode)
      OP_GET: begin
        rsp_opcode = D_ACCESS_ACK_DATA;
        if (legal) begin
          rsp_data = mem[word_idx];
        end else begin
          rsp_denied  = 1'b1;
          rsp_corrupt = 1'b1;
        end
      end
      OP_PUT_FULL, OP_PUT_PARTIAL: begin
        rsp_opcode = D_ACCESS_ACK;
        if (legal) begin
          wr_en = 1'b1;
        end else begin
          rsp_denied = 1'b1;
        end
      end
      OP_ARITH, OP_LOGIC: begin
        rsp_opcode  = D_ACCESS_ACK_DATA;
        rsp_denied  = 1'b1;
        rsp_corrupt = 1'b1;
      end
      OP_INTENT: begin
        rsp_opcode = D_HINT_ACK;
        rsp_denied = 1'b1;
      end
      default: begin
        rsp_opcode = D_ACCESS_ACK;
        rsp_denied = 1'b1;
      end
    endcase
  end

  // Masked byte writes on the A fire edge; contents survive reset
  always_ff @(posedge clock) begin
    if (!reset && a_fire && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (tl.a_mask[b]) begin
          mem[word_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
        end
      end
    end
  end

  // Single-entry response buffer: load on A fire, hold until D is taken
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_q   <= 1'b0;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 2'd0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= 32'h0;
    end else if (a_fire) begin
      d_valid_q   <= 1'b1;
      d_opcode_q  <= rsp_opcode;
      d_size_q    <= tl.a_size;
      d_source_q  <= tl.a_source;
      d_denied_q  <= rsp_denied;
      d_corrupt_q <= rsp_corrupt;
      d_data_q    <= rsp_data;
    end else if (tl.d_ready) begin
      d_valid_q   <= 1'b0;
    end
  end

  assign tl.a_ready   = a_ready_int;
  assign tl.d_valid   = d_valid_q;
  assign tl.d_opcode  = d_opcode_q;
  assign tl.d_param   = 2'd0;
  assign tl.d_size    = d_size_q;
  assign tl.d_source  = d_source_q;
  assign tl.d_sink    = 1'b0;
  assign tl.d_denied  = d_denied_q;
  assign tl.d_corrupt = d_corrupt_q;
  assign tl.d_data    = d_data_q;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder: drives A on the falling edge, checks D between edges.
// Latency: expects the D beat one cycle after each A fire.
// Backpressure: exercises d_ready stalls, back-to-back throughput and reset with a pending beat.
module tb_tl_ul_sram_responder;

  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PART = 3'd1;
  localparam logic [2:0] GET      = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [2:0] bad_op  [5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
  logic [2:0] bad_rsp [5] = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd0};
  logic       bad_cor [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  tl_ul_sram_responder_if #(.SRC_W(4)) tl();

  tl_ul_sram_responder #(
    .SRC_W     (4),
    .DEPTH     (256),
    .BASE_ADDR (32'h2000_0000)
  ) u_dut (
    .clock (clk),
    .reset (rst),
    .tl    (tl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [1:0] sz, input logic [3:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    tl.a_valid   = 1'b1;
    tl.a_opcode  = op;
    tl.a_param   = 3'd0;
    tl.a_size    = sz;
    tl.a_source  = src;
    tl.a_address = addr;
    tl.a_mask    = mask;
    tl.a_data    = data;
  endtask

  // One request issued at a falling edge, accepted at the next rising edge
  task automatic single(input string tag, input logic [2:0] op, input logic [1:0] sz,
                        input logic [3:0] src, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
    drive_a(op, sz, src, addr, mask, data);
    #1;
    chk({tag, ".a_ready"}, tl.a_ready, 1);
    @(negedge clk);
    tl.a_valid = 1'b0;
    #1;
  endtask

  task automatic expect_d(input string tag, input logic [2:0] op, input logic den,
                          input logic cor, input logic [31:0] data, input logic [3:0] src,
                          input logic [1:0] sz);
    chk({tag, ".d_valid"},   tl.d_valid, 1);
    chk({tag, ".d_opcode"},  tl.d_opcode, op);
    chk({tag, ".d_denied"},  tl.d_denied, den);
    chk({tag, ".d_corrupt"}, tl.d_corrupt, cor);
    chk({tag, ".d_data"},    tl.d_data, data);
    chk({tag, ".d_source"},  tl.d_source, src);
    chk({tag, ".d_size"},    tl.d_size, sz);
    chk({tag, ".d_param"},   tl.d_param, 0);
    chk({tag, ".d_sink"},    tl.d_sink, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tl.a_valid   = 1'b0;
    tl.a_opcode  = 3'd0;
    tl.a_param   = 3'd0;
    tl.a_size    = 2'd0;
    tl.a_source  = 4'd0;
    tl.a_address = 32'h0;
    tl.a_mask    = 4'h0;
    tl.a_data    = 32'h0;
    tl.d_ready   = 1'b1;
    rst          = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst.d_valid",   tl.d_valid, 0);
    chk("rst.a_ready",   tl.a_ready, 1);
    chk("rst.d_opcode",  tl.d_opcode, 0);
    chk("rst.d_size",    tl.d_size, 0);
    chk("rst.d_source",  tl.d_source, 0);
    chk("rst.d_denied",  tl.d_denied, 0);
    chk("rst.d_corrupt", tl.d_corrupt, 0);
    chk("rst.d_data",    tl.d_data, 0);
    rst = 1'b0;

    // PutFull then Get of the same word
    single("pf10", PUT_FULL, 2'd2, 4'd3, 32'h2000_0010, 4'hF, 32'hDEAD_BEEF);
    expect_d("pf10", 3'd0, 1'b0, 1'b0, 32'h0, 4'd3, 2'd2);
    single("g10", GET, 2'd2, 4'd5, 32'h2000_0010, 4'hF, 32'h0);
    expect_d("g10", 3'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'd5, 2'd2);

    // PutPartial on byte lane 2 merges into the existing word
    single("pp10", PUT_PART, 2'd2, 4'd6, 32'h2000_0010, 4'b0100, 32'h00AA_0000);
    expect_d("pp10", 3'd0, 1'b0, 1'b0, 32'h0, 4'd6, 2'd2);
    single("g10b", GET, 2'd2, 4'd2, 32'h2000_0010, 4'hF, 32'h0);
    expect_d("g10b", 3'd1, 1'b0, 1'b0, 32'hDEAA_BEEF, 4'd2, 2'd2);

    // Sub-word Gets still return the full word
    single("g13b", GET, 2'd0, 4'd1, 32'h2000_0013, 4'b1000, 32'h0);
    expect_d("g13b", 3'd1, 1'b0, 1'b0, 32'hDEAA_BEEF, 4'd1, 2'd0);
    single("g12h", GET, 2'd1, 4'd4, 32'h2000_0012, 4'b1100, 32'h0);
    expect_d("g12h", 3'd1, 1'b0, 1'b0, 32'hDEAA_BEEF, 4'd4, 2'd1);

    // Range boundaries
    single("goor", GET, 2'd2, 4'd9, 32'h2000_0400, 4'hF, 32'h0);
    expect_d("goor", 3'd1, 1'b1, 1'b1, 32'h0, 4'd9, 2'd2);
    single("glow", GET, 2'd2, 4'd9, 32'h1FFF_FFFC, 4'hF, 32'h0);
    expect_d("glow", 3'd1, 1'b1, 1'b1, 32'h0, 4'd9, 2'd2);
    single("pftop", PUT_FULL, 2'd2, 4'd7, 32'h2000_03FC, 4'hF, 32'h55AA_55AA);
    expect_d("pftop", 3'd0, 1'b0, 1'b0, 32'h0, 4'd7, 2'd2);
    single("gtop", GET, 2'd2, 4'd7, 32'h2000_03FC, 4'hF, 32'h0);
    expect_d("gtop", 3'd1, 1'b0, 1'b0, 32'h55AA_55AA, 4'd7, 2'd2);

    // Misalignment and bad masks
    single("pf00", PUT_FULL, 2'd2, 4'd1, 32'h2000_0000, 4'hF, 32'hCAFE_F00D);
    expect_d("pf00", 3'd0, 1'b0, 1'b0, 32'h0, 4'd1, 2'd2);
    single("gmis", GET, 2'd2, 4'd3, 32'h2000_0002, 4'hF, 32'h0);
    expect_d("gmis", 3'd1, 1'b1, 1'b1, 32'h0, 4'd3, 2'd2);
    single("pfbm", PUT_FULL, 2'd1, 4'd3, 32'h2000_0002, 4'b0011, 32'h1234_5678);
    expect_d("pfbm", 3'd0, 1'b1, 1'b0, 32'h0, 4'd3, 2'd1);
    single("ppz", PUT_PART, 2'd2, 4'd3, 32'h2000_0000, 4'b0000, 32'h1234_5678);
    expect_d("ppz", 3'd0, 1'b1, 1'b0, 32'h0, 4'd3, 2'd2);
    single("g00", GET, 2'd2, 4'd8, 32'h2000_0000, 4'hF, 32'h0);
    expect_d("g00", 3'd1, 1'b0, 1'b0, 32'hCAFE_F00D, 4'd8, 2'd2);

    // Unsupported opcodes never write
    single("pf30", PUT_FULL, 2'd2, 4'd0, 32'h2000_0030, 4'hF, 32'h0BAD_C0DE);
    expect_d("pf30", 3'd0, 1'b0, 1'b0, 32'h0, 4'd0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      single("unsup", bad_op[i], 2'd2, 4'(i), 32'h2000_0030, 4'hF, 32'hFFFF_FFFF);
      expect_d("unsup", bad_rsp[i], 1'b1, bad_cor[i], 32'h0, 4'(i), 2'd2);
    end
    single("g30", GET, 2'd2, 4'd5, 32'h2000_0030, 4'hF, 32'h0);
    expect_d("g30", 3'd1, 1'b0, 1'b0, 32'h0BAD_C0DE, 4'd5, 2'd2);

    // Read-after-write with no bubble between the Put and the Get
    drive_a(PUT_FULL, 2'd2, 4'd4, 32'h2000_0020, 4'hF, 32'h1122_3344);
    #1;
    chk("raw.put.a_ready", tl.a_ready, 1);
    @(negedge clk);
    drive_a(GET, 2'd2, 4'd5, 32'h2000_0020, 4'hF, 32'h0);
    #1;
    chk("raw.get.a_ready", tl.a_ready, 1);
    expect_d("raw.put", 3'd0, 1'b0, 1'b0, 32'h0, 4'd4, 2'd2);
    @(negedge clk);
    tl.a_valid = 1'b0;
    #1;
    expect_d("raw.get", 3'd1, 1'b0, 1'b0, 32'h1122_3344, 4'd5, 2'd2);
    @(negedge clk);
    #1;
    chk("drain.d_valid", tl.d_valid, 0);

    // D stall with A held valid, then full-rate drain of queued Gets
    tl.d_ready = 1'b0;
    drive_a(GET, 2'd2, 4'd7, 32'h2000_0010, 4'hF, 32'h0);
    #1;
    chk("stall.first.a_ready", tl.a_ready, 1);
    @(negedge clk);
    drive_a(GET, 2'd2, 4'd8, 32'h2000_0020, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall.a_ready", tl.a_ready, 0);
      expect_d("stall", 3'd1, 1'b0, 1'b0, 32'hDEAA_BEEF, 4'd7, 2'd2);
      @(negedge clk);
    end
    tl.d_ready = 1'b1;
    #1;
    chk("burst0.a_ready", tl.a_ready, 1);
    expect_d("burst0", 3'd1, 1'b0, 1'b0, 32'hDEAA_BEEF, 4'd7, 2'd2);
    @(negedge clk);
    drive_a(GET, 2'd2, 4'd9, 32'h2000_0030, 4'hF, 32'h0);
    #1;
    chk("burst1.a_ready", tl.a_ready, 1);
    expect_d("burst1", 3'd1, 1'b0, 1'b0, 32'h1122_3344, 4'd8, 2'd2);
    @(negedge clk);
    drive_a(GET, 2'd2, 4'd10, 32'h2000_0000, 4'hF, 32'h0);
    #1;
    chk("burst2.a_ready", tl.a_ready, 1);
    expect_d("burst2", 3'd1, 1'b0, 1'b0, 32'h0BAD_C0DE, 4'd9, 2'd2);
    @(negedge clk);
    drive_a(GET, 2'd2, 4'd11, 32'h2000_03FC, 4'hF, 32'h0);
    #1;
    chk("burst3.a_ready", tl.a_ready, 1);
    expect_d("burst3", 3'd1, 1'b0, 1'b0, 32'hCAFE_F00D, 4'd10, 2'd2);
    @(negedge clk);
    tl.a_valid = 1'b0;
    #1;
    expect_d("burst4", 3'd1, 1'b0, 1'b0, 32'h55AA_55AA, 4'd11, 2'd2);
    @(negedge clk);
    #1;
    chk("burst.end.d_valid", tl.d_valid, 0);

    // Reset while a response is pending
    tl.d_ready = 1'b0;
    drive_a(GET, 2'd2, 4'd12, 32'h2000_0010, 4'hF, 32'h0);
    @(negedge clk);
    tl.a_valid = 1'b0;
    #1;
    chk("mrst.pending.d_valid", tl.d_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst.d_valid",  tl.d_valid, 0);
    chk("mrst.a_ready",  tl.a_ready, 1);
    chk("mrst.d_source", tl.d_source, 0);
    chk("mrst.d_data",   tl.d_data, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst.after.d_valid", tl.d_valid, 0);
    chk("mrst.after.a_ready", tl.a_ready, 1);
    tl.d_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst.quiet.d_valid", tl.d_valid, 0);

    // Memory survives reset
    single("gpost", GET, 2'd2, 4'd13, 32'h2000_0010, 4'hF, 32'h0);
    expect_d("gpost", 3'd1, 1'b0, 1'b0, 32'hDEAA_BEEF, 4'd13, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
